// File: rtl/shift_pkg.sv
// Shared types and widths for the arbitrated 32-bit barrel-shift datapath.
package shift_pkg;

    typedef enum logic [1:0] {
        SHIFT_SLL  = 2'b00,
        SHIFT_SRL  = 2'b01,
        SHIFT_RSVD = 2'b10,
        SHIFT_SRA  = 2'b11
    } shift_op_e;

    localparam int XLEN    = 32;
    localparam int SHAMT_W = 5;

endpackage

// File: rtl/shift_arbiter_if.sv
// Request/response bundle between NUM_REQ shift requesters and the shared shifter.
interface shift_arbiter_if #(
    parameter int NUM_REQ = 2
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [2*NUM_REQ-1:0]  req_op;
    logic [32*NUM_REQ-1:0] req_data;
    logic [5*NUM_REQ-1:0]  req_shamt;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [31:0]           resp_data;
    logic [ID_W-1:0]       resp_id;

    modport master (
        output req_valid, req_op, req_data, req_shamt, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_id
    );

    modport slave (
        input  req_valid, req_op, req_data, req_shamt, resp_ready,
        output req_ready, resp_valid, resp_data, resp_id
    );
endinterface

// File: rtl/barrel_shift.sv
// Combinational 5-stage logarithmic shifter; left shifts reuse the right-shift
// network by reversing the operand on the way in and the result on the way out.
module barrel_shift
    import shift_pkg::*;
(
    input  shift_op_e         op,
    input  logic [XLEN-1:0]   data,
    input  logic [SHAMT_W-1:0] shamt,
    output logic [XLEN-1:0]   result
);

    logic            left;
    logic            fill;
    logic [XLEN-1:0] s;

    function automatic logic [XLEN-1:0] bit_rev(input logic [XLEN-1:0] v);
        logic [XLEN-1:0] r;
        for (int i = 0; i < XLEN; i++) r[i] = v[XLEN-1-i];
        return r;
    endfunction

    // Reserved encoding executes as a left shift.
    assign left = (op == SHIFT_SLL) || (op == SHIFT_RSVD);
    assign fill = (op == SHIFT_SRA) && data[XLEN-1];

    always_comb begin
        s = left ? bit_rev(data) : data;
        for (int k = 0; k < SHAMT_W; k++) begin
            if (shamt[k]) s = fill ? ~((~s) >> (1 << k)) : (s >> (1 << k));
        end
        result = left ? bit_rev(s) : s;
    end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one barrel shifter between NUM_REQ requesters,
// with a single-entry result register that can pop and refill in one cycle.
module shift_arbiter
    import shift_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    shift_arbiter_if.slave   bus
);

    localparam int ID_W = $clog2(NUM_REQ);

    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  gidx;
    logic [ID_W-1:0]  ptr_nxt;
    logic [ID_W:0]    cand;
    logic             grant_vld;
    logic             slot_free;
    logic             fire;
    shift_op_e        op_sel;
    logic [XLEN-1:0]  data_sel;
    logic [SHAMT_W-1:0] shamt_sel;
    logic [XLEN-1:0]  shift_res;

    logic             vld_p1;
    logic [XLEN-1:0]  data_p1;
    logic [ID_W-1:0]  id_p1;

    // Rotating priority search starting at rr_ptr.
    always_comb begin
        grant_vld = 1'b0;
        gidx      = '0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, rr_ptr} + (ID_W+1)'(i);
            if (cand >= (ID_W+1)'(NUM_REQ)) cand = cand - (ID_W+1)'(NUM_REQ);
            if (!grant_vld && bus.req_valid[cand[ID_W-1:0]]) begin
                grant_vld = 1'b1;
                gidx      = cand[ID_W-1:0];
            end
        end
    end

    assign slot_free     = !vld_p1 || bus.resp_ready;
    assign fire          = grant_vld && slot_free && rst_n;
    assign bus.req_ready = fire ? (NUM_REQ'(1) << gidx) : '0;
    assign ptr_nxt       = (gidx == ID_W'(NUM_REQ-1)) ? '0 : gidx + ID_W'(1);

    assign op_sel    = shift_op_e'(bus.req_op[int'(gidx)*2 +: 2]);
    assign data_sel  = bus.req_data[int'(gidx)*32 +: 32];
    assign shamt_sel = bus.req_shamt[int'(gidx)*5 +: 5];

    barrel_shift u_shift (
        .op     (op_sel),
        .data   (data_sel),
        .shamt  (shamt_sel),
        .result (shift_res)
    );

    // Stage p1: result register; data/id hold unless a new grant fires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            id_p1   <= '0;
            rr_ptr  <= '0;
        end else if (fire) begin
            vld_p1  <= 1'b1;
            data_p1 <= shift_res;
            id_p1   <= gidx;
            rr_ptr  <= ptr_nxt;
        end else if (bus.resp_ready) begin
            vld_p1  <= 1'b0;
        end
    end

    assign bus.resp_valid = vld_p1;
    assign bus.resp_data  = data_p1;
    assign bus.resp_id    = id_p1;

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter with two requesters.
module tb_shift_arbiter;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    shift_arbiter_if #(.NUM_REQ(2)) bus ();

    shift_arbiter #(.NUM_REQ(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic drive_req(input int i, input logic v, input logic [1:0] op,
                             input logic [31:0] d, input logic [4:0] sh);
        bus.req_valid[i]        = v;
        bus.req_op[i*2 +: 2]    = op;
        bus.req_data[i*32 +: 32] = d;
        bus.req_shamt[i*5 +: 5] = sh;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        bus.req_valid = 2'b11;
        #2;
        checks++;
        if (bus.req_ready !== 2'b00) begin
            failures++; $display("FAIL reset_ready got=%b exp=00", bus.req_ready);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.resp_valid !== 1'b0 || bus.resp_data !== 32'h0 || bus.resp_id !== 1'b0) begin
            failures++;
            $display("FAIL reset_state got v=%b d=%h id=%b exp v=0 d=0 id=0",
                     bus.resp_valid, bus.resp_data, bus.resp_id);
        end
        @(negedge clk);
        bus.req_valid = 2'b00;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        @(negedge clk);
        drive_req(0, 1'b1, 2'b00, 32'h0000_0001, 5'd31);
        #1;
        checks++;
        if (bus.req_ready !== 2'b01) begin
            failures++; $display("FAIL single_ready got=%b exp=01", bus.req_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.resp_valid !== 1'b1 || bus.resp_data !== 32'h8000_0000 || bus.resp_id !== 1'b0) begin
            failures++;
            $display("FAIL single_resp got v=%b d=%h id=%b exp v=1 d=80000000 id=0",
                     bus.resp_valid, bus.resp_data, bus.resp_id);
        end
    endtask

    task automatic test_ops();
        logic [1:0]  ops  [4] = '{2'b01, 2'b11, 2'b11, 2'b10};
        logic [31:0] din  [4] = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h0000_0001};
        logic [4:0]  shs  [4] = '{5'd4, 5'd4, 5'd0, 5'd1};
        logic [31:0] exp  [4] = '{32'h0800_0000, 32'hF800_0000, 32'h8000_0000, 32'h0000_0002};
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            bus.req_valid[0] = 1'b0;
            drive_req(1, 1'b1, ops[t], din[t], shs[t]);
            #1;
            checks++;
            if (bus.req_ready !== 2'b10) begin
                failures++; $display("FAIL op%0d_ready got=%b exp=10", t, bus.req_ready);
            end
            @(posedge clk); #1;
            checks++;
            if (bus.resp_valid !== 1'b1 || bus.resp_data !== exp[t] || bus.resp_id !== 1'b1) begin
                failures++;
                $display("FAIL op%0d_resp got v=%b d=%h id=%b exp v=1 d=%h id=1",
                         t, bus.resp_valid, bus.resp_data, bus.resp_id, exp[t]);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [1:0]  exp_rdy;
        logic        exp_id;
        logic [31:0] exp_d;
        @(negedge clk);
        drive_req(0, 1'b1, 2'b00, 32'h0000_00F0, 5'd4);
        drive_req(1, 1'b1, 2'b11, 32'hF000_0000, 5'd4);
        for (int t = 0; t < 4; t++) begin
            exp_id  = (t % 2 == 1);
            exp_rdy = exp_id ? 2'b10 : 2'b01;
            exp_d   = exp_id ? 32'hFF00_0000 : 32'h0000_0F00;
            if (t != 0) @(negedge clk);
            #1;
            checks++;
            if (bus.req_ready !== exp_rdy) begin
                failures++; $display("FAIL rr%0d_ready got=%b exp=%b", t, bus.req_ready, exp_rdy);
            end
            @(posedge clk); #1;
            checks++;
            if (bus.resp_valid !== 1'b1 || bus.resp_id !== exp_id || bus.resp_data !== exp_d) begin
                failures++;
                $display("FAIL rr%0d_resp got v=%b id=%b d=%h exp v=1 id=%b d=%h",
                         t, bus.resp_valid, bus.resp_id, bus.resp_data, exp_id, exp_d);
            end
        end
    endtask

    task automatic test_back_to_back_stall();
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            bus.resp_ready = 1'b0;
            #1;
            checks++;
            if (bus.req_ready !== 2'b00) begin
                failures++; $display("FAIL stall%0d_ready got=%b exp=00", t, bus.req_ready);
            end
            @(posedge clk); #1;
            checks++;
            if (bus.resp_valid !== 1'b1 || bus.resp_id !== 1'b1 || bus.resp_data !== 32'hFF00_0000) begin
                failures++;
                $display("FAIL stall%0d_hold got v=%b id=%b d=%h exp v=1 id=1 d=ff000000",
                         t, bus.resp_valid, bus.resp_id, bus.resp_data);
            end
        end
        @(negedge clk);
        bus.resp_ready = 1'b1;
        #1;
        checks++;
        if (bus.req_ready !== 2'b01) begin
            failures++; $display("FAIL release_ready got=%b exp=01", bus.req_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.resp_valid !== 1'b1 || bus.resp_id !== 1'b0 || bus.resp_data !== 32'h0000_0F00) begin
            failures++;
            $display("FAIL release_resp got v=%b id=%b d=%h exp v=1 id=0 d=00000f00",
                     bus.resp_valid, bus.resp_id, bus.resp_data);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.resp_valid !== 1'b0 || bus.resp_data !== 32'h0 || bus.resp_id !== 1'b0
            || bus.req_ready !== 2'b00) begin
            failures++;
            $display("FAIL async_reset got v=%b d=%h id=%b rdy=%b exp all zero",
                     bus.resp_valid, bus.resp_data, bus.resp_id, bus.req_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.req_ready !== 2'b01) begin
            failures++; $display("FAIL post_reset_ready got=%b exp=01", bus.req_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.resp_valid !== 1'b1 || bus.resp_id !== 1'b0 || bus.resp_data !== 32'h0000_0F00) begin
            failures++;
            $display("FAIL post_reset_resp got v=%b id=%b d=%h exp v=1 id=0 d=00000f00",
                     bus.resp_valid, bus.resp_id, bus.resp_data);
        end
    endtask

    task automatic test_idle_fairness();
        @(negedge clk);
        bus.req_valid = 2'b10;
        #1;
        checks++;
        if (bus.req_ready !== 2'b10) begin
            failures++; $display("FAIL idle_grant1 got=%b exp=10", bus.req_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.resp_id !== 1'b1 || bus.resp_data !== 32'hFF00_0000) begin
            failures++; $display("FAIL idle_resp1 got id=%b d=%h exp id=1 d=ff000000",
                                 bus.resp_id, bus.resp_data);
        end
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            bus.req_valid = 2'b00;
            #1;
            checks++;
            if (bus.req_ready !== 2'b00) begin
                failures++; $display("FAIL idle%0d_ready got=%b exp=00", t, bus.req_ready);
            end
            @(posedge clk); #1;
            checks++;
            if (bus.resp_valid !== 1'b0 || bus.resp_id !== 1'b1 || bus.resp_data !== 32'hFF00_0000) begin
                failures++;
                $display("FAIL idle%0d_resp got v=%b id=%b d=%h exp v=0 id=1 d=ff000000",
                         t, bus.resp_valid, bus.resp_id, bus.resp_data);
            end
        end
        @(negedge clk);
        bus.req_valid = 2'b11;
        #1;
        checks++;
        if (bus.req_ready !== 2'b01) begin
            failures++; $display("FAIL fair_ready got=%b exp=01", bus.req_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.resp_valid !== 1'b1 || bus.resp_id !== 1'b0 || bus.resp_data !== 32'h0000_0F00) begin
            failures++;
            $display("FAIL fair_resp got v=%b id=%b d=%h exp v=1 id=0 d=00000f00",
                     bus.resp_valid, bus.resp_id, bus.resp_data);
        end
    endtask

    initial begin
        bus.req_valid  = '0;
        bus.req_op     = '0;
        bus.req_data   = '0;
        bus.req_shamt  = '0;
        bus.resp_ready = 1'b1;
        test_reset();
        test_single();
        test_ops();
        test_round_robin();
        test_back_to_back_stall();
        test_async_reset();
        test_idle_fairness();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/shift_arbiter.md
Name: shift_arbiter

Overview:
- Shares one 32-bit barrel-shift datapath between NUM_REQ requesters (e.g. ALU shift path and CSR/debug path) using round-robin arbitration.
- Each requester uses a valid/ready request channel; one common response channel carries the result and the requester ID.
- The result register is single-entry: one shift is granted per cycle at most, and the result appears one cycle after the grant.

Parameters:
- NUM_REQ, 2, number of requesters; legal range 2..8.
- ID_W, $clog2(NUM_REQ), width of the requester ID; derived, not overridden.

Ports:
- clk  in  1  system clock; rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_op  in  2*NUM_REQ  per-requester op, slice i = [2i+1:2i]. Encoding: 00 SLL, 01 SRL, 11 SRA, 10 reserved.
- req_data  in  32*NUM_REQ  per-requester operand, slice i = [32i+31:32i].
- req_shamt  in  5*NUM_REQ  per-requester shift amount, slice i = [5i+4:5i].
- resp_valid  out  1  result valid.
- resp_ready  in  1  consumer accepts the result.
- resp_data  out  32  shifted result.
- resp_id  out  ID_W  index of the requester that owns resp_data.

Behaviour:
- Reset (async assert, sync deassert by the system):
  - resp_valid=0, resp_data=0, resp_id=0, rr_ptr=0.
  - req_ready=0 while rst_n=0.
  - Reset mid-operation discards any pending result, with no response.
- Free condition: slot_free = !resp_valid || resp_ready.
- Arbitration:
  - Combinational. Search starts at rr_ptr and proceeds rr_ptr, rr_ptr+1, ... wrapping mod NUM_REQ.
  - The first index with req_valid=1 is granted.
  - req_ready[g]=1 only if slot_free; all other bits are 0.
  - With no valid request, req_ready=0.
  - req_ready does not depend on the granted requester's own req_valid, apart from the search itself (no combinational loop through ready).
- Handshake fire: req_valid[g] && req_ready[g]. On the next clock edge:
  - resp_data <= shift(req_op[g], req_data[g], req_shamt[g]).
  - resp_id <= g, resp_valid <= 1.
  - rr_ptr <= (g+1) mod NUM_REQ.
- No fire and resp_valid && resp_ready: resp_valid <= 0. resp_data and resp_id hold their last values.
- Stall (resp_valid && !resp_ready):
  - No grant; rr_ptr is unchanged.
  - resp_data and resp_id are held bit-stable until accepted.
- Simultaneous pop and fire in the same cycle: the new result replaces the old one and resp_valid stays 1. Sustained throughput is 1 result/cycle.
- Latency is exactly 1 cycle from fire to resp_valid.
- rr_ptr advances only on fire, so idle cycles do not perturb fairness. A requester holding valid high waits at most NUM_REQ-1 grants.
- Shift arithmetic:
  - SLL fills with zeros; SRL fills with zeros; SRA fills with data[31].
  - shamt=0 passes data through unchanged. shamt=31 is the maximum; no shamt is modulo-wrapped beyond 5 bits.
  - Reserved op 10 executes as SLL (deterministic, no error flag).
- Requesters must hold op, data and shamt stable while valid is high and unaccepted. The block does not sample them otherwise.

Decomposition:
- Package shift_pkg holds:
  - typedef enum logic [1:0] shift_op_e {SHIFT_SLL=2'b00, SHIFT_SRL=2'b01, SHIFT_RSVD=2'b10, SHIFT_SRA=2'b11}.
  - localparam XLEN=32 and SHAMT_W=5.
- One combinational sub-module, barrel_shift, implements the 5-stage log shifter for all three ops. It uses a fill bit (0, or data[31] for SRA) and reverses bits for left shifts.
- Arbiter, pointer and response register stay in shift_arbiter.

Test Plan:
- Reset then single request: req0 valid, op SLL, data 0x0000_0001, shamt 31, resp_ready=1.
  -> req_ready=01 in cycle 0; next cycle resp_valid=1, resp_data=0x8000_0000, resp_id=0.
- Op coverage on req1 with data 0x8000_0000, shamt 4:
  - SRL -> 0x0800_0000.
  - SRA -> 0xF800_0000.
  - shamt 0 with SRA -> 0x8000_0000.
  - Reserved op 10 with data 0x1, shamt 1 -> 0x0000_0002.
- Round-robin: both requesters valid continuously, resp_ready=1.
  -> grants alternate 0,1,0,1 starting from req0; resp_id follows one cycle later; one result every cycle.
- Backpressure: resp_valid=1 with resp_ready=0 for 3 cycles while both requests are valid.
  -> req_ready=00 throughout; resp_data/resp_id unchanged.
  -> On the cycle resp_ready=1, the next requester in round-robin order is granted and its result appears the following cycle.
- Async reset mid-stream: assert rst_n=0 between clock edges while resp_valid=1.
  -> resp_valid, resp_data, resp_id drop to 0 immediately.
  -> After release with both requests valid, the first grant goes to req0.
- Idle fairness: req1 granted, then 5 idle cycles, then both valid.
  -> req0 is granted first (rr_ptr=0 retained through idle).
